// File: rtl/fb_ddr_write_combiner_pkg.sv
// Shared widths, byte-enable constants and the staged/queued write entry type
// for the framebuffer-to-DDRAM write combiner.
package fb_ddr_write_combiner_pkg;

    localparam int unsigned FBW_ADDR_W  = 29;
    localparam int unsigned FBW_DATA_W  = 64;
    localparam int unsigned FBW_BE_W    = 8;
    localparam int unsigned FBW_PIX_W   = 32;
    localparam int unsigned FBW_ENTRY_W = FBW_ADDR_W + FBW_DATA_W + FBW_BE_W;

    localparam logic [FBW_BE_W-1:0] BE_LO = 8'h0F;
    localparam logic [FBW_BE_W-1:0] BE_HI = 8'hF0;

    typedef struct packed {
        logic [FBW_ADDR_W-1:0] addr;
        logic [FBW_DATA_W-1:0] data;
        logic [FBW_BE_W-1:0]   be;
    } fbw_entry_t;

    function automatic logic [FBW_BE_W-1:0] fbw_half_be(input logic hi);
        return hi ? BE_HI : BE_LO;
    endfunction

endpackage

// File: rtl/fb_wr_fifo.sv
// Synchronous show-ahead FIFO: a RAM-style store plus a registered head stage, so
// the head is stable while the consumer stalls and the next entry shows the cycle after a pop.
module fb_wr_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic [AW:0]      level
);

    localparam int unsigned DEPTH     = 2 ** AW;
    localparam logic [AW:0] LEVEL_MAX = {1'b1, {AW{1'b0}}};

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_dout;
    logic             r_out_valid;

    logic        w_mem_empty;
    logic        w_mem_full;
    logic        w_pop;
    logic        w_wr;
    logic        w_load;
    logic [AW:0] w_mem_cnt;

    always_comb begin
        w_mem_empty = (r_wr_ptr == r_rd_ptr);
        w_mem_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
        w_pop       = pop && r_out_valid;
        w_wr        = push && !w_mem_full;
        // Refill the head stage whenever it is free or being consumed this cycle.
        w_load      = !w_mem_empty && (!r_out_valid || w_pop);
        w_mem_cnt   = r_wr_ptr - r_rd_ptr;
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_dout      <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_load) begin
                r_dout      <= r_mem[r_rd_ptr[AW-1:0]];
                r_rd_ptr    <= r_rd_ptr + 1'b1;
                r_out_valid <= 1'b1;
            end else if (w_pop) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign dout  = r_dout;
    assign empty = !r_out_valid;
    assign level = w_mem_cnt + {{AW{1'b0}}, r_out_valid};
    assign full  = (level == LEVEL_MAX);

endmodule

// File: rtl/fb_ddr_write_combiner.sv
// Merges 32-bit pixel writes into byte-enabled 64-bit DDRAM writes through a
// staging register and a show-ahead FIFO that absorbs DDRAM_BUSY stalls.
module fb_ddr_write_combiner
    import fb_ddr_write_combiner_pkg::*;
#(
    parameter int unsigned AW         = 4,
    parameter int unsigned IDLE_FLUSH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_we,
    input  logic [FBW_ADDR_W-1:0] in_addr,
    input  logic                  in_hi,
    input  logic [FBW_PIX_W-1:0]  in_data,
    input  logic                  in_flush,
    output logic                  DDRAM_CLK,
    input  logic                  DDRAM_BUSY,
    output logic [7:0]            DDRAM_BURSTCNT,
    output logic [FBW_ADDR_W-1:0] DDRAM_ADDR,
    output logic [FBW_DATA_W-1:0] DDRAM_DIN,
    output logic [FBW_BE_W-1:0]   DDRAM_BE,
    output logic                  DDRAM_WE,
    output logic                  DDRAM_RD,
    output logic [AW:0]           level,
    output logic                  overflow
);

    localparam int unsigned   CW       = $clog2(IDLE_FLUSH + 1);
    localparam logic [CW-1:0] IDLE_MAX = CW'(IDLE_FLUSH);
    localparam logic [CW-1:0] IDLE_HIT = CW'(IDLE_FLUSH - 1);

    fbw_entry_t    r_stage;
    logic          r_valid;
    logic [CW-1:0] r_idle_cnt;
    logic          r_overflow;

    fbw_entry_t             w_stage_nxt;
    logic                   w_valid_nxt;
    logic [CW-1:0]          w_idle_nxt;
    logic                   w_merge;
    logic                   w_idle_hit;
    logic                   w_flush;
    logic                   w_need_push;
    logic                   w_can_push;
    logic                   w_push;
    logic                   w_drop;
    logic                   w_pop;
    logic                   w_fifo_empty;
    logic                   w_fifo_full;
    logic [FBW_ENTRY_W-1:0] w_head_bits;
    fbw_entry_t             w_head;

    fb_wr_fifo #(
        .WIDTH (FBW_ENTRY_W),
        .AW    (AW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .din   (r_stage),
        .pop   (w_pop),
        .dout  (w_head_bits),
        .empty (w_fifo_empty),
        .full  (w_fifo_full),
        .level (level)
    );

    assign w_head = fbw_entry_t'(w_head_bits);
    assign w_pop  = DDRAM_WE && !DDRAM_BUSY;

    always_comb begin
        w_merge     = in_we && !in_flush && r_valid && (r_stage.addr == in_addr);
        // Fires on the cycle the idle count reaches IDLE_FLUSH, and keeps retrying if the FIFO is full.
        w_idle_hit  = r_valid && !in_we && (r_idle_cnt >= IDLE_HIT);
        w_flush     = in_flush || w_idle_hit;
        w_need_push = r_valid && (w_flush || (in_we && !w_merge));
        w_can_push  = !w_fifo_full || w_pop;
        w_push      = w_need_push && w_can_push;
        w_drop      = in_we && w_need_push && !w_can_push;
    end

    always_comb begin
        w_stage_nxt = r_stage;
        w_valid_nxt = r_valid;
        if (in_we) begin
            if (w_merge) begin
                if (in_hi) begin
                    w_stage_nxt.data[FBW_DATA_W-1:FBW_PIX_W] = in_data;
                end else begin
                    w_stage_nxt.data[FBW_PIX_W-1:0] = in_data;
                end
                w_stage_nxt.be = r_stage.be | fbw_half_be(in_hi);
            end else if (!w_drop) begin
                w_stage_nxt.addr = in_addr;
                w_stage_nxt.data = {in_data, in_data};
                w_stage_nxt.be   = fbw_half_be(in_hi);
                w_valid_nxt      = 1'b1;
            end
        end else if (w_push) begin
            w_valid_nxt = 1'b0;
        end

        w_idle_nxt = r_idle_cnt;
        if (in_we) begin
            w_idle_nxt = '0;
        end else if (r_idle_cnt != IDLE_MAX) begin
            w_idle_nxt = r_idle_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stage    <= '0;
            r_valid    <= 1'b0;
            r_idle_cnt <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_stage    <= w_stage_nxt;
            r_valid    <= w_valid_nxt;
            r_idle_cnt <= w_idle_nxt;
            r_overflow <= r_overflow | w_drop;
        end
    end

    assign DDRAM_CLK      = clk;
    assign DDRAM_BURSTCNT = 8'd1;
    assign DDRAM_RD       = 1'b0;
    assign DDRAM_WE       = !w_fifo_empty;
    assign DDRAM_ADDR     = w_head.addr;
    assign DDRAM_DIN      = w_head.data;
    assign DDRAM_BE       = w_head.be;
    assign overflow       = r_overflow;

endmodule
